// File: rtl/plugboard_pkg.sv
// Shared types and constants for the programmable Enigma plugboard.
package plugboard_pkg;

  localparam int LETTER_W    = 5;
  localparam int NUM_LETTERS = 26;

  typedef logic [LETTER_W-1:0] letter_t;

  localparam letter_t LAST_LETTER = letter_t'(NUM_LETTERS - 1);

  localparam letter_t A = 5'd0;
  localparam letter_t B = 5'd1;
  localparam letter_t C = 5'd2;
  localparam letter_t D = 5'd3;
  localparam letter_t E = 5'd4;
  localparam letter_t F = 5'd5;
  localparam letter_t G = 5'd6;
  localparam letter_t H = 5'd7;
  localparam letter_t I = 5'd8;
  localparam letter_t J = 5'd9;
  localparam letter_t K = 5'd10;
  localparam letter_t L = 5'd11;
  localparam letter_t M = 5'd12;
  localparam letter_t N = 5'd13;
  localparam letter_t O = 5'd14;
  localparam letter_t P = 5'd15;
  localparam letter_t Q = 5'd16;
  localparam letter_t R = 5'd17;
  localparam letter_t S = 5'd18;
  localparam letter_t T = 5'd19;
  localparam letter_t U = 5'd20;
  localparam letter_t V = 5'd21;
  localparam letter_t W = 5'd22;
  localparam letter_t X = 5'd23;
  localparam letter_t Y = 5'd24;
  localparam letter_t Z = 5'd25;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_RANGE    = 3'd1,
    ERR_SELF     = 3'd2,
    ERR_CONFLICT = 3'd3,
    ERR_FULL     = 3'd4
  } err_e;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  function automatic logic in_range(input letter_t l);
    return l <= LAST_LETTER;
  endfunction

endpackage

// File: rtl/plugboard_pair_check.sv
// Combinational validation of one swap pair against the current table; first failing rule wins.
module plugboard_pair_check
  import plugboard_pkg::*;
#(
  parameter int unsigned MAX_PAIRS = 13
) (
  input  letter_t    pair_a_i,
  input  letter_t    pair_b_i,
  input  letter_t    tab_a_i,
  input  letter_t    tab_b_i,
  input  logic [3:0] pair_count_i,
  output err_e       err_code_o
);

  // NOTE: assigning a default before any branch keeps this block free of inferred latches.
  always_comb begin
    err_code_o = ERR_NONE;
    if (!in_range(pair_a_i) || !in_range(pair_b_i)) begin
      err_code_o = ERR_RANGE;
    end else if (pair_a_i == pair_b_i) begin
      err_code_o = ERR_SELF;
    end else if ((tab_a_i != pair_a_i) || (tab_b_i != pair_b_i)) begin
      err_code_o = ERR_CONFLICT;
    end else if (pair_count_i == 4'(MAX_PAIRS)) begin
      err_code_o = ERR_FULL;
    end
  end

endmodule

// File: rtl/plugboard_loader.sv
// Run-time programmable plugboard: host loads swap pairs, rotor datapath reads registered lookups.
module plugboard_loader
  import plugboard_pkg::*;
#(
  parameter int unsigned MAX_PAIRS = 13
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cfg_clear,
  input  logic       pair_valid,
  output logic       pair_ready,
  input  logic [4:0] pair_a,
  input  logic [4:0] pair_b,
  input  logic       cfg_commit,
  output logic       cfg_active,
  output logic       cfg_error,
  output logic [2:0] err_code,
  output logic [3:0] pair_count,
  input  logic       lk_valid_in,
  input  logic [4:0] lk_in,
  output logic       lk_valid_out,
  output logic [4:0] lk_out
);

  state_e     state_q, state_d;
  letter_t    table_q [NUM_LETTERS];
  letter_t    table_d [NUM_LETTERS];
  letter_t    clr_idx_q, clr_idx_d;
  logic [3:0] count_q, count_d;
  logic       error_q, error_d;
  err_e       err_q, err_d;
  logic       lk_valid_q;
  letter_t    lk_out_q, lk_out_d;

  letter_t    tab_a, tab_b;
  err_e       pair_err;

  // Out-of-range letters never index the table; the range rule rejects them first anyway.
  assign tab_a = in_range(pair_a) ? table_q[pair_a] : pair_a;
  assign tab_b = in_range(pair_b) ? table_q[pair_b] : pair_b;

  plugboard_pair_check #(
    .MAX_PAIRS(MAX_PAIRS)
  ) u_pair_check (
    .pair_a_i    (pair_a),
    .pair_b_i    (pair_b),
    .tab_a_i     (tab_a),
    .tab_b_i     (tab_b),
    .pair_count_i(count_q),
    .err_code_o  (pair_err)
  );

  always_comb begin
    state_d   = state_q;
    table_d   = table_q;
    clr_idx_d = clr_idx_q;
    count_d   = count_q;
    error_d   = error_q;
    err_d     = err_q;

    if (cfg_clear) begin
      state_d   = ST_CLEAR;
      clr_idx_d = '0;
      count_d   = '0;
      error_d   = 1'b0;
      err_d     = ERR_NONE;
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
          table_d[clr_idx_q] = clr_idx_q;
          if (clr_idx_q == LAST_LETTER) begin
            state_d   = ST_LOAD;
            clr_idx_d = '0;
          end else begin
            clr_idx_d = clr_idx_q + letter_t'(1);
          end
        end
        ST_LOAD: begin
          if (pair_valid) begin
            if (pair_err == ERR_NONE) begin
              table_d[pair_a] = pair_b;
              table_d[pair_b] = pair_a;
              count_d         = count_q + 4'd1;
            end else begin
              error_d = 1'b1;
              if (!error_q) err_d = pair_err;
            end
          end
          // The pair above is still applied on the commit cycle.
          if (cfg_commit) state_d = ST_ACTIVE;
        end
        ST_ACTIVE: ;
        default: state_d = ST_LOAD;
      endcase
    end
  end

  // Lookups read the registered table, so a write in the same cycle is not yet visible.
  always_comb begin
    lk_out_d = lk_out_q;
    if (lk_valid_in) begin
      if ((state_q == ST_CLEAR) || !in_range(lk_in)) lk_out_d = lk_in;
      else                                           lk_out_d = table_q[lk_in];
    end
  end

  // NOTE: the table must come out of reset as identity, so every entry sits on the async reset
  // here rather than in a RAM; sequential state is written with <= only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_LOAD;
      for (int i = 0; i < NUM_LETTERS; i++) table_q[i] <= letter_t'(i);
      clr_idx_q  <= '0;
      count_q    <= '0;
      error_q    <= 1'b0;
      err_q      <= ERR_NONE;
      lk_valid_q <= 1'b0;
      lk_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      table_q    <= table_d;
      clr_idx_q  <= clr_idx_d;
      count_q    <= count_d;
      error_q    <= error_d;
      err_q      <= err_d;
      lk_valid_q <= lk_valid_in;
      lk_out_q   <= lk_out_d;
    end
  end

  assign pair_ready   = (state_q == ST_LOAD);
  assign cfg_active   = (state_q == ST_ACTIVE);
  assign cfg_error    = error_q;
  assign err_code     = err_q;
  assign pair_count   = count_q;
  assign lk_valid_out = lk_valid_q;
  assign lk_out       = lk_out_q;

endmodule

// File: tb/tb_plugboard_loader.sv
// Self-checking bench for plugboard_loader against a letter-array model of the plugboard.
module tb_plugboard_loader;
  import plugboard_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cfg_clear = 1'b0, pair_valid = 1'b0, cfg_commit = 1'b0, lk_valid_in = 1'b0;
  logic [4:0] pair_a = '0, pair_b = '0, lk_in = '0;

  logic       pair_ready, cfg_active, cfg_error, lk_valid_out;
  logic [2:0] err_code;
  logic [3:0] pair_count;
  logic [4:0] lk_out;

  logic       s_pair_ready, s_cfg_active, s_cfg_error, s_lk_valid_out;
  logic [2:0] s_err_code;
  logic [3:0] s_pair_count;
  logic [4:0] s_lk_out;

  always #5 clk = ~clk;

  plugboard_loader u_dut (
    .clk(clk), .reset_n(reset_n), .cfg_clear(cfg_clear),
    .pair_valid(pair_valid), .pair_ready(pair_ready), .pair_a(pair_a), .pair_b(pair_b),
    .cfg_commit(cfg_commit), .cfg_active(cfg_active), .cfg_error(cfg_error),
    .err_code(err_code), .pair_count(pair_count),
    .lk_valid_in(lk_valid_in), .lk_in(lk_in), .lk_valid_out(lk_valid_out), .lk_out(lk_out)
  );

  // A 4-pair instance makes the FULL rule reachable: with 26 letters, 13 pairs use every letter.
  plugboard_loader #(.MAX_PAIRS(4)) u_small (
    .clk(clk), .reset_n(reset_n), .cfg_clear(cfg_clear),
    .pair_valid(pair_valid), .pair_ready(s_pair_ready), .pair_a(pair_a), .pair_b(pair_b),
    .cfg_commit(cfg_commit), .cfg_active(s_cfg_active), .cfg_error(s_cfg_error),
    .err_code(s_err_code), .pair_count(s_pair_count),
    .lk_valid_in(lk_valid_in), .lk_in(lk_in), .lk_valid_out(s_lk_valid_out), .lk_out(s_lk_out)
  );

  int checks = 0;
  int errors = 0;

  // Model: partner of each letter, accepted count, first error, phase (0 clear, 1 load, 2 active).
  int m_tab [26];
  int m_count;
  bit m_err;
  int m_code;
  int m_state;

  function automatic void m_reset();
    for (int i = 0; i < 26; i++) m_tab[i] = i;
    m_count = 0; m_err = 0; m_code = 0; m_state = 1;
  endfunction

  function automatic int m_classify(input int a, input int b);
    if (a > 25 || b > 25) return 1;
    if (a == b) return 2;
    if (m_tab[a] != a || m_tab[b] != b) return 3;
    if (m_count == 13) return 4;
    return 0;
  endfunction

  function automatic void m_pair(input int a, input int b);
    int c;
    c = m_classify(a, b);
    if (c == 0) begin
      m_tab[a] = b; m_tab[b] = a; m_count++;
    end else begin
      if (!m_err) m_code = c;
      m_err = 1;
    end
  endfunction

  function automatic int m_lookup(input int l);
    if (m_state == 0 || l > 25) return l;
    return m_tab[l];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    checks++;
    if (pair_count !== 4'(m_count)) begin
      errors++;
      $display("FAIL %s pair_count: got %0d expected %0d", tag, pair_count, m_count);
    end
    checks++;
    if (cfg_error !== m_err || err_code !== 3'(m_code)) begin
      errors++;
      $display("FAIL %s error: got %0b/%0d expected %0b/%0d", tag, cfg_error, err_code, m_err, m_code);
    end
    checks++;
    if (cfg_active !== (m_state == 2) || pair_ready !== (m_state == 1)) begin
      errors++;
      $display("FAIL %s phase: got active=%0b ready=%0b expected phase %0d", tag, cfg_active, pair_ready, m_state);
    end
  endtask

  task automatic send_pair(input int a, input int b, input bit commit);
    pair_valid = 1'b1; pair_a = a[4:0]; pair_b = b[4:0]; cfg_commit = commit;
    tick();
    pair_valid = 1'b0; cfg_commit = 1'b0;
    if (m_state == 1) begin
      m_pair(a, b);
      if (commit) m_state = 2;
    end
    check_status($sformatf("pair %0d-%0d", a, b));
  endtask

  task automatic commit_cfg();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    if (m_state == 1) m_state = 2;
    check_status("commit");
  endtask

  task automatic lookup(input int l);
    int exp;
    exp = m_lookup(l);
    lk_valid_in = 1'b1; lk_in = l[4:0];
    tick();
    lk_valid_in = 1'b0;
    checks++;
    if (lk_valid_out !== 1'b1 || lk_out !== 5'(exp)) begin
      errors++;
      $display("FAIL lookup %0d: got valid=%0b out=%0d expected valid=1 out=%0d", l, lk_valid_out, lk_out, exp);
    end
  endtask

  task automatic sweep();
    for (int l = 0; l < 26; l++) lookup(l);
  endtask

  // Pulses cfg_clear (optionally again at CLEAR step restart_at) and walks out the CLEAR phase.
  task automatic do_clear(input bit stream, input int restart_at);
    int l, exp;
    l = $urandom_range(0, 31);
    exp = m_lookup(l);
    cfg_clear = 1'b1; lk_valid_in = stream; lk_in = l[4:0];
    tick();
    cfg_clear = 1'b0;
    if (stream) begin
      checks++;
      if (lk_out !== 5'(exp)) begin
        errors++;
        $display("FAIL clear-edge lookup %0d: got %0d expected %0d", l, lk_out, exp);
      end
    end
    m_reset();
    m_state = 0;
    for (int i = 0; i < 26; i++) begin
      checks++;
      if (pair_ready !== 1'b0 || cfg_active !== 1'b0 || pair_count !== 4'd0 || cfg_error !== 1'b0) begin
        errors++;
        $display("FAIL clear step %0d: got ready=%0b active=%0b count=%0d err=%0b expected 0/0/0/0",
                 i, pair_ready, cfg_active, pair_count, cfg_error);
      end
      l = $urandom_range(0, 31);
      lk_in = l[4:0];
      pair_valid = stream; pair_a = 5'($urandom_range(0, 25)); pair_b = 5'($urandom_range(0, 25));
      if (i == restart_at) cfg_clear = 1'b1;
      tick();
      cfg_clear = 1'b0; pair_valid = 1'b0;
      if (stream) begin
        checks++;
        if (lk_out !== 5'(l)) begin
          errors++;
          $display("FAIL clear identity lookup %0d: got %0d expected %0d", l, lk_out, l);
        end
      end
      if (i == restart_at) begin
        restart_at = -1;
        i = -1;
      end
    end
    lk_valid_in = 1'b0;
    m_state = 1;
    check_status("after clear");
  endtask

  task automatic test_reset();
    check_status("reset");
    checks++;
    if (lk_valid_out !== 1'b0 || lk_out !== 5'd0) begin
      errors++;
      $display("FAIL reset lookup regs: got valid=%0b out=%0d expected 0/0", lk_valid_out, lk_out);
    end
    lookup(M);
    lookup(26);
    tick();
    checks++;
    if (lk_valid_out !== 1'b0 || lk_out !== 5'd26) begin
      errors++;
      $display("FAIL lookup hold: got valid=%0b out=%0d expected 0/26", lk_valid_out, lk_out);
    end
  endtask

  task automatic test_commit();
    send_pair(A, M, 0); send_pair(C, N, 0); send_pair(D, P, 0);
    send_pair(E, Q, 0); send_pair(F, S, 0); send_pair(G, V, 0);
    commit_cfg();
    lookup(A); lookup(M); lookup(N); lookup(B); lookup(Z);
    // Frozen table: pairs and a second commit are ignored while active.
    send_pair(B, Y, 0);
    commit_cfg();
    sweep();
  endtask

  task automatic test_conflict();
    do_clear(0, -1);
    send_pair(A, M, 0);
    send_pair(A, Z, 0);
    lookup(Z); lookup(A);
    send_pair(Q, Q, 0);
    sweep();
  endtask

  task automatic test_full();
    int perm [26];
    int j, t;
    do_clear(0, -1);
    for (int i = 0; i < 26; i++) perm[i] = i;
    for (int i = 25; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int p = 0; p < 13; p++) send_pair(perm[2*p], perm[2*p+1], 0);
    send_pair(perm[0], perm[2], 0);
    checks++;
    if (s_pair_count !== 4'd4 || s_cfg_error !== 1'b1 || s_err_code !== 3'd4) begin
      errors++;
      $display("FAIL full-limit: got count=%0d err=%0b code=%0d expected 4/1/4", s_pair_count, s_cfg_error, s_err_code);
    end
    lookup(perm[8]);
    checks++;
    if (s_lk_out !== 5'(perm[8])) begin
      errors++;
      $display("FAIL full-limit rejected lookup: got %0d expected %0d", s_lk_out, perm[8]);
    end
    lookup(perm[0]);
    checks++;
    if (s_lk_out !== 5'(perm[1])) begin
      errors++;
      $display("FAIL full-limit accepted lookup: got %0d expected %0d", s_lk_out, perm[1]);
    end
    sweep();
  endtask

  task automatic test_clear_mid_load();
    do_clear(0, -1);
    send_pair(B, K, 0); send_pair(H, W, 0); send_pair(H, X, 0);
    do_clear(1, -1);
    sweep();
  endtask

  task automatic test_clear_restart();
    send_pair(J, R, 0);
    do_clear(1, 10);
    sweep();
  endtask

  task automatic test_random();
    int n, a, b;
    for (int r = 0; r < 4; r++) begin
      do_clear(0, -1);
      n = $urandom_range(4, 18);
      for (int k = 0; k < n; k++) begin
        a = ($urandom_range(0, 7) == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25);
        b = ($urandom_range(0, 7) == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25);
        if ($urandom_range(0, 9) == 0) b = a;
        send_pair(a, b, k == n - 1);
      end
      sweep();
      lookup($urandom_range(26, 31));
    end
  endtask

  task automatic test_async_reset();
    do_clear(0, -1);
    send_pair(B, Y, 1);
    lk_valid_in = 1'b1; lk_in = B;
    tick();
    checks++;
    if (lk_valid_out !== 1'b1 || lk_out !== Y) begin
      errors++;
      $display("FAIL pre-reset lookup: got valid=%0b out=%0d expected 1/%0d", lk_valid_out, lk_out, Y);
    end
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    check_status("async reset");
    checks++;
    if (lk_valid_out !== 1'b0 || lk_out !== 5'd0) begin
      errors++;
      $display("FAIL async reset lookup regs: got valid=%0b out=%0d expected 0/0", lk_valid_out, lk_out);
    end
    lk_valid_in = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++;
    if (lk_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL post-reset valid: got %0b expected 0", lk_valid_out);
    end
    check_status("post reset");
    sweep();
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    test_reset();
    test_commit();
    test_conflict();
    test_full();
    test_clear_mid_load();
    test_clear_restart();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
